// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the integer register file slice.
//   DATA_W   : register width in bits
//   ADDR_W   : register address width
//   NREGS    : number of architectural registers (2**ADDR_W)
//   ZERO_REG : index of the hard-wired zero register (XZR)
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [NREGS-1:0]  reg_onehot_t;

endpackage

// File: rtl/decoder5_32.sv
// ---------------------------------------------------------------------------
// decoder5_32
// Enable-gated 5:32 one-hot decoder. A 2:4 stage on the upper select bits
// picks one of four banks, and each bank is a 3:8 stage on the lower bits.
// Ports:
//   i_en  : decoder enable; all outputs low when 0
//   i_sel : 5-bit select
//   o_dec : one-hot output, bit i high iff i_en=1 and i_sel==i
// ---------------------------------------------------------------------------
module decoder5_32 (
  input  logic        i_en,
  input  logic [4:0]  i_sel,
  output logic [31:0] o_dec
);

  logic [3:0] w_bank;

  // 2:4 bank select on sel[4:3], gated by the enable
  assign w_bank[0] = i_en & ~i_sel[4] & ~i_sel[3];
  assign w_bank[1] = i_en & ~i_sel[4] &  i_sel[3];
  assign w_bank[2] = i_en &  i_sel[4] & ~i_sel[3];
  assign w_bank[3] = i_en &  i_sel[4] &  i_sel[3];

  // Four 3:8 decoders on sel[2:0], each enabled by its bank line
  for (genvar b = 0; b < 4; b++) begin : g_bank
    for (genvar k = 0; k < 8; k++) begin : g_line
      localparam logic [2:0] LK = 3'(k);
      assign o_dec[b*8+k] = w_bank[b]
                          & (i_sel[2] ~^ LK[2])
                          & (i_sel[1] ~^ LK[1])
                          & (i_sel[0] ~^ LK[0]);
    end
  end

endmodule

// File: rtl/regfile_sync_bypass.sv
// ---------------------------------------------------------------------------
// regfile_sync_bypass
// 32 x 64-bit integer register file: one write port, two registered read
// ports with same-cycle write-to-read bypass. Register 31 (XZR) reads zero.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset (0 = in reset)
//   wr_en     : write-back enable
//   wr_addr   : write-back destination register
//   wr_data   : write-back value
//   rd_addr_a : operand A source register
//   rd_addr_b : operand B source register
//   hold      : stall; freezes the read output registers
//   rd_data_a : registered operand A
//   rd_data_b : registered operand B
// ---------------------------------------------------------------------------
module regfile_sync_bypass
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              hold,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  reg_onehot_t w_enVec;
  reg_data_t   w_storage [NREGS];
  reg_addr_t   w_rdAddr  [2];
  reg_data_t   w_next    [2];
  reg_data_t   r_rdDataA;
  reg_data_t   r_rdDataB;

  decoder5_32 u_decoder (
    .i_en  (wr_en),
    .i_sel (wr_addr),
    .o_dec (w_enVec)
  );

  // One storage register per architectural register; XZR has no flop and
  // is tied to zero so writes to it vanish.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      assign w_storage[g] = '0;
    end else begin : g_flop
      reg_data_t r_value;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_value <= '0;
        end else if (w_enVec[g]) begin
          r_value <= wr_data;
        end
      end

      assign w_storage[g] = r_value;
    end
  end

  assign w_rdAddr[0] = rd_addr_a;
  assign w_rdAddr[1] = rd_addr_b;

  // Next operand per port: XZR wins, then a same-cycle write to the same
  // register (the decoder line for that address is the match), then storage.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_next[p] = w_storage[w_rdAddr[p]];
      if (w_enVec[w_rdAddr[p]]) begin
        w_next[p] = wr_data;
      end
      if (w_rdAddr[p] == reg_addr_t'(ZERO_REG)) begin
        w_next[p] = '0;
      end
    end
  end

  // Operand output registers, frozen while the pipeline is stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdDataA <= '0;
      r_rdDataB <= '0;
    end else if (!hold) begin
      r_rdDataA <= w_next[0];
      r_rdDataB <= w_next[1];
    end
  end

  assign rd_data_a = r_rdDataA;
  assign rd_data_b = r_rdDataB;

endmodule
